// File: rtl/line_window_buf.sv
// rtl/line_window_buf.sv - raster line buffer emitting one NUM_LINES+1 tap vertical column per accepted pixel
// Row-count masking hides stale line RAM contents, so the RAMs never need clearing.
module line_window_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 640,
  parameter int NUM_LINES  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sof,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]    line_len,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              out_valid,
  output logic [DATA_WIDTH*(NUM_LINES+1)-1:0] out_data,
  output logic [$clog2(MAX_WIDTH)-1:0]      out_col,
  output logic                              out_eol,
  output logic                              out_primed
);

  localparam int LEN_W = $clog2(MAX_WIDTH + 1);
  localparam int COL_W = $clog2(MAX_WIDTH);
  localparam int ROW_W = $clog2(NUM_LINES + 1);
  localparam int TAP_W = DATA_WIDTH * (NUM_LINES + 1);

  logic [COL_W-1:0]              col;
  logic [ROW_W-1:0]              row_cnt;
  logic [LEN_W-1:0]              len_q;

  logic [LEN_W-1:0]              len_clamp;
  logic [COL_W-1:0]              col_eff;
  logic [ROW_W-1:0]              row_eff;
  logic [LEN_W-1:0]              len_eff;
  logic                          at_eol;
  logic [TAP_W-1:0]              tap_next;
  logic [DATA_WIDTH*NUM_LINES-1:0] old_flat;

  // A sof pixel already belongs to the new frame, so pointers and length are bypassed.
  always_comb begin
    len_clamp = line_len;
    if (line_len == '0 || line_len > LEN_W'(MAX_WIDTH))
      len_clamp = LEN_W'(MAX_WIDTH);
    col_eff = sof ? '0 : col;
    row_eff = sof ? '0 : row_cnt;
    len_eff = sof ? len_clamp : len_q;
    at_eol  = (LEN_W'(col_eff) == len_eff - LEN_W'(1));
  end

  for (genvar j = 0; j < NUM_LINES; j++) begin : g_line
    logic [DATA_WIDTH-1:0] mem [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] wr_data;

    if (j == 0) begin : g_head
      assign wr_data = in_data;
    end else begin : g_chain
      assign wr_data = old_flat[(j-1)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign old_flat[j*DATA_WIDTH +: DATA_WIDTH] = mem[col_eff];

    always_ff @(posedge clk) begin
      if (rst_n && in_valid)
        mem[col_eff] <= wr_data;
    end
  end

  always_comb begin
    tap_next = '0;
    tap_next[DATA_WIDTH-1:0] = in_data;
    for (int k = 1; k <= NUM_LINES; k++) begin
      if (row_eff >= ROW_W'(k))
        tap_next[k*DATA_WIDTH +: DATA_WIDTH] = old_flat[(k-1)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row_cnt    <= '0;
      len_q      <= LEN_W'(MAX_WIDTH);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_col    <= '0;
      out_eol    <= 1'b0;
      out_primed <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (sof)
        len_q <= len_clamp;
      if (in_valid) begin
        out_data   <= tap_next;
        out_col    <= col_eff;
        out_eol    <= at_eol;
        out_primed <= (row_eff == ROW_W'(NUM_LINES));
        if (at_eol) begin
          col     <= '0;
          row_cnt <= (row_eff == ROW_W'(NUM_LINES)) ? row_eff : row_eff + ROW_W'(1);
        end else begin
          col     <= col_eff + COL_W'(1);
          row_cnt <= row_eff;
        end
      end else if (sof) begin
        col     <= '0;
        row_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_line_window_buf.sv
// tb/tb_line_window_buf.sv - directed self-checking bench for line_window_buf
module tb_line_window_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sof = 1'b0;
  logic [3:0]  line_len = 4'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        out_valid;
  logic [23:0] out_data;
  logic [2:0]  out_col;
  logic        out_eol;
  logic        out_primed;

  int n_checks = 0;
  int n_pass   = 0;

  // {slice2, slice1, slice0} for pixels 1..12 of a 4-wide frame
  logic [23:0] fill_data [12] = '{
    24'h000001, 24'h000002, 24'h000003, 24'h000004,
    24'h000105, 24'h000206, 24'h000307, 24'h000408,
    24'h010509, 24'h02060a, 24'h03070b, 24'h04080c
  };

  line_window_buf #(.DATA_WIDTH(8), .MAX_WIDTH(8), .NUM_LINES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sof        (sof),
    .line_len   (line_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_eol    (out_eol),
    .out_primed (out_primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 ns after the edge.
  task automatic drive(input logic r, input logic s, input logic [3:0] len,
                       input logic v, input logic [7:0] d);
    @(negedge clk);
    rst_n = r; sof = s; line_len = len; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] d);
    drive(1'b1, 1'b0, 4'd0, 1'b1, d);
  endtask

  task automatic frame_start(input logic [3:0] len);
    drive(1'b1, 1'b1, len, 1'b0, 8'd0);
  endtask

  initial begin
    // Reset held with valid input
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 8'(8'hA0 + i));
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_primed", 32'(out_primed), 32'd0);
    end
    pix(8'hAA);
    chk("rst_first_valid", 32'(out_valid), 32'd1);
    chk("rst_first_col", 32'(out_col), 32'd0);
    drive(1'b1, 1'b0, 4'd0, 1'b0, 8'd0);
    chk("rst_idle_valid", 32'(out_valid), 32'd0);

    // Fill/prime
    frame_start(4'd4);
    for (int p = 1; p <= 12; p++) begin
      pix(8'(p));
      chk($sformatf("fill_data_%0d", p), 32'(out_data), 32'(fill_data[p-1]));
      chk($sformatf("fill_col_%0d", p), 32'(out_col), 32'((p-1) % 4));
      chk($sformatf("fill_eol_%0d", p), 32'(out_eol), 32'(p == 4 || p == 8 || p == 12));
      chk($sformatf("fill_primed_%0d", p), 32'(out_primed), 32'(p >= 9));
    end

    // Bubbles: same stream with gaps, outputs hold during gaps
    frame_start(4'd4);
    for (int p = 1; p <= 12; p++) begin
      int gaps;
      pix(8'(p));
      chk($sformatf("bub_valid_%0d", p), 32'(out_valid), 32'd1);
      chk($sformatf("bub_data_%0d", p), 32'(out_data), 32'(fill_data[p-1]));
      chk($sformatf("bub_col_%0d", p), 32'(out_col), 32'((p-1) % 4));
      chk($sformatf("bub_eol_%0d", p), 32'(out_eol), 32'(p == 4 || p == 8 || p == 12));
      gaps = (p % 2 == 1) ? 1 : int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) begin
        drive(1'b1, 1'b0, 4'd0, 1'b0, 8'hEE);
        chk($sformatf("bub_gap_valid_%0d", p), 32'(out_valid), 32'd0);
        chk($sformatf("bub_hold_%0d", p), 32'(out_data), 32'(fill_data[p-1]));
      end
    end

    // Length clamp: 0 and 9 both mean 8
    for (int t = 0; t < 2; t++) begin
      frame_start(t == 0 ? 4'd0 : 4'd9);
      for (int i = 0; i < 16; i++) begin
        pix(8'(i + 1));
        chk($sformatf("clamp%0d_col_%0d", t, i), 32'(out_col), 32'(i % 8));
        chk($sformatf("clamp%0d_eol_%0d", t, i), 32'(out_eol), 32'(i % 8 == 7));
      end
    end
    frame_start(4'd3);
    for (int i = 0; i < 7; i++) begin
      pix(8'(i + 1));
      chk($sformatf("len3_col_%0d", i), 32'(out_col), 32'(i % 3));
      chk($sformatf("len3_eol_%0d", i), 32'(out_eol), 32'(i % 3 == 2));
    end

    // Mid-frame sof with a pixel in the same cycle
    frame_start(4'd4);
    for (int p = 1; p <= 6; p++) pix(8'(p));
    drive(1'b1, 1'b1, 4'd4, 1'b1, 8'd100);
    chk("msof_col", 32'(out_col), 32'd0);
    chk("msof_data", 32'(out_data), 32'h000064);
    chk("msof_primed", 32'(out_primed), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      pix(8'(100 + k));
      chk($sformatf("msof_primed_%0d", k), 32'(out_primed), 32'(k == 8));
      if (k == 4) chk("msof_row1_data", 32'(out_data), 32'h006468);
      if (k == 8) chk("msof_row2_data", 32'(out_data), 32'h64686c);
    end

    // Reset mid-line: line length returns to 8 after reset
    frame_start(4'd4);
    for (int p = 1; p <= 10; p++) pix(8'(p));
    drive(1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
    for (int k = 0; k < 17; k++) begin
      pix(8'(50 + k));
      if (k == 0) begin
        chk("rml_col", 32'(out_col), 32'd0);
        chk("rml_data", 32'(out_data), 32'h000032);
      end
      if (k == 8) chk("rml_row1_data", 32'(out_data), 32'h00323a);
      chk($sformatf("rml_eol_%0d", k), 32'(out_eol), 32'(k % 8 == 7));
      chk($sformatf("rml_primed_%0d", k), 32'(out_primed), 32'(k == 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
